data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL take parameters: DEPTH_WORDS, default 256, number of 32-bit memory words; WAIT_STATES, default 1, extra cycles inserted before each response (0..15).
REQ-002 Clk  input  1  single rising-edge clock.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Req_Valid  input  1  processor MEM stage presents a request.
REQ-005 Req_Ready  output  1  responder accepts a request this cycle.
REQ-006 Req_Write  input  1  1 = store, 0 = load.
REQ-007 Req_Addr  input  32  byte address.
REQ-008 Req_WData  input  32  store data, right-aligned.
REQ-009 Req_Funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 Rsp_Valid  output  1  response available.
REQ-011 Rsp_Ready  input  1  processor consumes the response.
REQ-012 Rsp_RData  output  32  load data, sign- or zero-extended; 0 for stores.
REQ-013 Rsp_Err  output  1  misaligned, out-of-range, or illegal-Funct3 access.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT and RESP, with one outstanding request maximum.
REQ-015 Req_Ready SHALL be 1 only in IDLE; a request is accepted on a Clk edge when Req_Valid and Req_Ready are both 1.
REQ-016 On acceptance, the block SHALL latch Write, Addr, WData and Funct3 internally, load the wait counter with WAIT_STATES, and go to WAIT (or to RESP when WAIT_STATES is 0).
REQ-017 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP in the cycle after the counter reaches 1.
REQ-018 Accept-to-Rsp_Valid latency SHALL be exactly WAIT_STATES+1 cycles.
REQ-019 In RESP, Rsp_Valid SHALL be 1 and Rsp_RData/Rsp_Err SHALL be held stable until Rsp_Ready is 1; on that edge the FSM SHALL return to IDLE.
REQ-020 When Rsp_Valid and Rsp_Ready are both 1, a new request SHALL NOT be accepted in the same cycle; Req_Ready rises the following cycle.
REQ-021 Word index SHALL be Addr[log2(DEPTH_WORDS)+1:2]; the access is out-of-range if any Addr bit above that field is nonzero.
REQ-022 The access SHALL be misaligned if: H/HU with Addr[0]=1; or W with Addr[1:0]!=00.
REQ-023 Funct3 values 011, 110 and 111, and 100/101 on a store, SHALL be illegal.
REQ-024 Loads SHALL select the byte or halfword by Addr[1:0] (little-endian), sign-extend for B/H, and zero-extend for BU/HU.
REQ-025 Stores SHALL write only the addressed byte lanes (SB one lane, SH two lanes, SW four lanes), leaving other lanes unchanged.
REQ-026 The memory write SHALL occur on the edge entering RESP.
REQ-027 Any erroring access SHALL set Rsp_Err=1 and Rsp_RData=0, and SHALL leave memory unmodified.
REQ-028 Inputs SHALL be ignored while the FSM is not in IDLE.

Reset
REQ-029 Asserting Reset (low) SHALL immediately force IDLE, Req_Ready=0, Rsp_Valid=0, Rsp_RData=0, Rsp_Err=0, and the wait counter to 0.
REQ-030 Req_Ready SHALL become 1 on the first Clk edge after Reset deasserts.
REQ-031 Reset asserted mid-transaction SHALL drop the pending response; if it arrives before the RESP entry edge, no memory write occurs.
REQ-032 Memory contents SHALL NOT be cleared by reset; contents are initialised only by simulation preload.

Structure
REQ-033 The Funct3 width codes, the FSM state encodings, and the DEPTH_WORDS default SHALL live in a shared package used by the processor and this block.
REQ-034 Byte-lane steering and extension SHALL be a combinational sub-module, mem_lane_align (Funct3, Addr[1:0], data in -> byte enables, aligned write data, extended read data).
REQ-035 The storage array SHALL be a plain register array inside data_mem_responder.

Verification
REQ-036 WAIT_STATES=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> Rsp_RData=0xDEADBEEF, with Rsp_Valid asserted 2 cycles after each accept.
REQ-037 After word 0x10=0xDEADBEEF:
- LB @0x13 -> 0xFFFFFFDE
- LBU @0x13 -> 0x000000DE
- LH @0x12 -> 0xFFFFDEAD
- LHU @0x10 -> 0x0000BEEF
REQ-038 SB 0x55 @0x11 on word 0xDEADBEEF -> LW @0x10 returns 0xDEAD55EF.
REQ-039 LW @0x12, SH @0x01, and LW @0x400 (DEPTH 256) -> each returns Rsp_Err=1 with Rsp_RData=0, and memory is unchanged.
REQ-040 Hold Rsp_Ready=0 for 5 cycles -> Rsp_Valid, Rsp_RData and Req_Ready=0 all stay stable; Req_Ready rises one cycle after the handshake.
REQ-041 Assert Reset during WAIT of SW 0x12345678 @0x20 -> Rsp_Valid stays 0, Req_Ready=0 while Reset is low, and a later LW @0x20 returns the old value.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared width codes, FSM states and default memory depth
package data_mem_responder_pkg;
    localparam int DEPTH_WORDS_DEFAULT = 256;
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores and extraction/extension for loads
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    assign byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
    assign half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    // Replicate store data across lanes, pick enables, extend the selected load field
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                be_o    = 4'b0011 << addr_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            F3_BU: rdata_o = {24'h0, byte_sel};
            F3_HU: rdata_o = {16'h0, half_sel};
            default: ;
        endcase
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated single-outstanding data memory for a RV32I MEM stage
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        write_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  funct3_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept, enter_resp, misalign, illegal, oor, err;
    logic        cur_write;
    logic [31:0] cur_addr, cur_wdata, word_addr;
    logic [2:0]  cur_funct3;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wdata_al, rdata_al;

    assign accept = req_valid_i && ready_q;

    // With zero wait states RESP is entered on the accept edge, before the latch holds the request
    assign cur_write  = (state_q == ST_IDLE) ? req_write_i  : write_q;
    assign cur_addr   = (state_q == ST_IDLE) ? req_addr_i   : addr_q;
    assign cur_wdata  = (state_q == ST_IDLE) ? req_wdata_i  : wdata_q;
    assign cur_funct3 = (state_q == ST_IDLE) ? req_funct3_i : funct3_q;

    assign word_addr = {2'b00, cur_addr[31:2]};
    assign idx       = word_addr[AW-1:0];
    assign oor       = word_addr >= 32'(DEPTH_WORDS);
    assign misalign  = ((cur_funct3 == F3_H || cur_funct3 == F3_HU) && cur_addr[0]) ||
                       (cur_funct3 == F3_W && cur_addr[1:0] != 2'b00);
    assign illegal   = !(cur_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ||
                       (cur_write && cur_funct3[2]);
    assign err       = misalign | illegal | oor;
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    mem_lane_align u_align (
        .funct3_i (cur_funct3),
        .addr_i   (cur_addr[1:0]),
        .wdata_i  (cur_wdata),
        .rdata_i  (mem_q[idx]),
        .be_o     (be),
        .wdata_o  (wdata_al),
        .rdata_o  (rdata_al)
    );

    // Next state, wait countdown and registered ready (high only while IDLE, low in reset)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                cnt_d   = 4'(WAIT_STATES);
            end
            ST_WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q <= 4'd1) ? ST_RESP : ST_WAIT;
            end
            ST_RESP: state_d = rsp_ready_i ? ST_IDLE : ST_RESP;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // FSM state, counter and ready registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Capture the request fields on acceptance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_q  <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            funct3_q <= 3'b000;
        end else if (accept) begin
            write_q  <= req_write_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            funct3_q <= req_funct3_i;
        end
    end

    // Response data/error frozen on RESP entry, cleared on handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= (err || cur_write) ? 32'h0 : rdata_al;
            err_q   <= err;
        end else if (state_q == ST_RESP && rsp_ready_i) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end
    end

    // Byte-enabled store on the edge entering RESP; contents survive reset
    always_ff @(posedge clk_i) begin
        if (enter_resp && cur_write && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_q[idx][8*i +: 8] <= wdata_al[8*i +: 8];
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks against a byte-level memory model
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] mem_b [4*DEPTH];

    localparam bit          DIR_W [8] = '{1, 0, 0, 0, 0, 0, 1, 0};
    localparam logic [31:0] DIR_A [8] = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h12, 32'h10, 32'h11, 32'h10};
    localparam logic [31:0] DIR_D [8] = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h55, 0};
    localparam logic [2:0]  DIR_F [8] = '{3'd2, 3'd2, 3'd0, 3'd4, 3'd1, 3'd5, 3'd0, 3'd2};
    localparam logic [31:0] DIR_R [8] = '{32'h0, 32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE,
                                          32'hFFFFDEAD, 32'h0000BEEF, 32'h0, 32'hDEAD55EF};

    localparam bit          ERR_W [8] = '{1, 0, 1, 0, 0, 1, 0, 0};
    localparam logic [31:0] ERR_A [8] = '{32'h00, 32'h12, 32'h01, 32'h400, 32'h10, 32'h10, 32'h10, 32'h00};
    localparam logic [31:0] ERR_D [8] = '{32'h01234567, 0, 32'hAAAA, 0, 0, 32'h77, 0, 0};
    localparam logic [2:0]  ERR_F [8] = '{3'd2, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd2};
    localparam bit          ERR_E [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    localparam logic [31:0] ERR_R [8] = '{32'h0, 0, 0, 0, 0, 0, 32'hDEAD55EF, 32'h01234567};

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_funct3_i (req_funct3),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: byte-addressed memory; access size from the width code, errors from the access rules
    function automatic void model_apply(input bit w, input logic [31:0] a, input logic [31:0] d,
                                        input logic [2:0] f, output logic [31:0] rd, output bit err);
        int size;
        bit legal;
        size  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        legal = (f == 3'd0 || f == 3'd1 || f == 3'd2 || (!w && (f == 3'd4 || f == 3'd5)));
        err   = !legal || (a % size != 0) || (a >= 4 * DEPTH);
        rd    = 32'h0;
        if (!err) begin
            for (int i = 0; i < size; i++)
                if (w) mem_b[a + i] = d[8*i +: 8];
                else   rd = rd | (32'(mem_b[a + i]) << (8 * i));
            if (!w && !f[2] && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFFFFFF << (8 * size));
        end
    endfunction

    task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                        input int hold, input bit pre_valid, output logic [31:0] rd, output logic e,
                        output int lat, output bit stable, output logic rdy_after);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_funct3 = 3'($urandom);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat >= 50) lat = -1;
        rd = rsp_rdata;
        e = rsp_err;
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== e || req_ready !== 1'b0) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        if (pre_valid) begin req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_funct3 = 3'd2; end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        rdy_after = req_ready;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/valid/err=%b expected 000", {req_ready, rsp_valid, rsp_err});
        end
        n_cmp++;
        if (rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 00000000", rsp_rdata);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b expected 0", req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_first_edge: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd, mrd;
        logic e, ra;
        bit me, st;
        int lat;
        for (int i = 0; i < 8; i++) begin
            xact(DIR_W[i], DIR_A[i], DIR_D[i], DIR_F[i], 0, 0, rd, e, lat, st, ra);
            model_apply(DIR_W[i], DIR_A[i], DIR_D[i], DIR_F[i], mrd, me);
            n_cmp++;
            if (rd !== DIR_R[i] || e !== 1'b0) begin
                n_fail++;
                $display("FAIL directed[%0d]: rdata=%h err=%b expected rdata=%h err=0", i, rd, e, DIR_R[i]);
            end
            n_cmp++;
            if (lat !== WS + 1) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, WS + 1);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, mrd;
        logic e, ra;
        bit me, st;
        int lat;
        for (int i = 0; i < 8; i++) begin
            xact(ERR_W[i], ERR_A[i], ERR_D[i], ERR_F[i], 0, 0, rd, e, lat, st, ra);
            model_apply(ERR_W[i], ERR_A[i], ERR_D[i], ERR_F[i], mrd, me);
            n_cmp++;
            if (rd !== ERR_R[i] || e !== ERR_E[i] || lat !== WS + 1) begin
                n_fail++;
                $display("FAIL errors[%0d]: rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=%0d",
                         i, rd, e, lat, ERR_R[i], ERR_E[i], WS + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic e, ra;
        bit st;
        int lat;
        xact(1'b0, 32'h10, 32'h0, 3'd2, 5, 0, rd, e, lat, st, ra);
        n_cmp++;
        if (rd !== 32'hDEAD55EF || e !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_data: rdata=%h err=%b expected DEAD55EF/0", rd, e);
        end
        n_cmp++;
        if (st !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_stable: got %b expected 1", st);
        end
        n_cmp++;
        if (ra !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_handshake: got %b expected 1", ra);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic e, ra;
        bit st;
        int lat;
        xact(1'b0, 32'h00, 32'h0, 3'd2, 0, 1, rd, e, lat, st, ra);
        n_cmp++;
        if (ra !== 1'b1 || rd !== 32'h01234567) begin
            n_fail++;
            $display("FAIL no_accept_on_handshake: ready=%b rdata=%h expected 1/01234567", ra, rd);
        end
        xact(1'b0, 32'h10, 32'h0, 3'd2, 0, 0, rd, e, lat, st, ra);
        n_cmp++;
        if (rd !== 32'hDEAD55EF || lat !== WS + 1) begin
            n_fail++;
            $display("FAIL back_to_back: rdata=%h lat=%0d expected DEAD55EF/%0d", rd, lat, WS + 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, mrd;
        logic e, ra;
        bit me, st;
        int lat, n;
        xact(1'b1, 32'h20, 32'hCAFEF00D, 3'd2, 0, 0, rd, e, lat, st, ra);
        model_apply(1'b1, 32'h20, 32'hCAFEF00D, 3'd2, mrd, me);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'd2;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_immediate: valid/ready=%b expected 00", {rsp_valid, req_ready});
        end
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({rsp_valid, req_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_mid_held: valid/ready=%b expected 00", {rsp_valid, req_ready});
            end
        end
        @(negedge clk); rst_n = 1'b1;
        xact(1'b0, 32'h20, 32'h0, 3'd2, 0, 0, rd, e, lat, st, ra);
        model_apply(1'b0, 32'h20, 32'h0, 3'd2, mrd, me);
        n_cmp++;
        if (rd !== 32'hCAFEF00D || rd !== mrd || e !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_write: rdata=%h err=%b expected CAFEF00D/0", rd, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, a, d;
        logic e, ra;
        bit me, st, w;
        logic [2:0] f;
        int lat;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            xact(1'b1, 32'(4 * i), d, 3'd2, 0, 0, rd, e, lat, st, ra);
            model_apply(1'b1, 32'(4 * i), d, 3'd2, mrd, me);
        end
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom);
            f = 3'($urandom);
            d = $urandom;
            a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 63));
            xact(w, a, d, f, 0, 0, rd, e, lat, st, ra);
            model_apply(w, a, d, f, mrd, me);
            n_cmp++;
            if (rd !== mrd || e !== me || lat !== WS + 1) begin
                n_fail++;
                $display("FAIL random[%0d] w=%b a=%h f=%0d: rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=%0d",
                         i, w, a, f, rd, e, lat, mrd, me, WS + 1);
            end
        end
    endtask

    initial begin
        foreach (mem_b[i]) mem_b[i] = 8'h00;
        test_reset();
        test_directed();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
